mem_arbiter: RTL

//  Shared single-port word memory with an N-port req/rdy arbiter; replaces the never-deny

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Request/ready bus between the memory requesters and
//                mem_arbiter. Each requester owns one bit of req/we/rdy and
//                one AW/DW slice of addr/wdata; rdata and gnt_id are shared.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int AW     = 16,
    parameter int DW     = 16
);
    localparam int c_IDW = $clog2(NPORTS);

    logic [NPORTS-1:0]    req;
    logic [NPORTS-1:0]    we;
    logic [NPORTS*AW-1:0] addr;
    logic [NPORTS*DW-1:0] wdata;
    logic [NPORTS-1:0]    rdy;
    logic [DW-1:0]        rdata;
    logic [c_IDW-1:0]     gnt_id;

    // Requester side
    modport master (
        output req, we, addr, wdata,
        input  rdy, rdata, gnt_id
    );

    // Arbiter side
    modport slave (
        input  req, we, addr, wdata,
        output rdy, rdata, gnt_id
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Single-port word memory shared by NPORTS requesters. One
//                access is granted per clock and acknowledged by a one-cycle
//                rdy pulse on the following clock. Round-robin arbitration
//                by default; defining ARB_FIXED_PRIO_EN switches to fixed
//                priority (lowest index wins). Out-of-range addresses drop
//                writes and return MISS_DATA on reads, but are still acked.
//  Config      : ARB_FIXED_PRIO_EN (optional macro)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int            NPORTS     = 4,
    parameter int            AW         = 16,
    parameter int            DW         = 16,
    parameter int            DEPTH_LOG2 = 9,
    parameter logic [DW-1:0] MISS_DATA  = 16'hEEEE
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);
    localparam int c_IDW   = $clog2(NPORTS);
    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [NPORTS-1:0]     r_rdy;
    logic [DW-1:0]         r_rdata;
    logic [c_IDW-1:0]      r_gnt_id;
    logic [DW-1:0]         r_mem [c_DEPTH];

    logic [NPORTS-1:0]     w_elig;
    logic                  w_gnt_valid;
    logic [c_IDW-1:0]      w_gnt_idx;
    logic                  w_sel_we;
    logic [AW-1:0]         w_sel_addr;
    logic [DW-1:0]         w_sel_wdata;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_mem_idx;
    logic                  w_wr_en;

    // A port that is being acked this cycle is not eligible again until the
    // next one, so a held req is never counted twice for the same transfer.
    assign w_elig = bus.req & ~r_rdy;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-index eligible port wins (scan high to low so
    // the last hit is the lowest index).
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = c_IDW'(i);
            end
        end
    end
`else
    logic [c_IDW-1:0] r_ptr;

    // Port index at distance off (1..NPORTS) after ptr, wrapping at NPORTS
    // (which need not be a power of two).
    function automatic logic [c_IDW-1:0] rr_idx(input logic [c_IDW-1:0] ptr,
                                               input int off);
        int s;
        s = int'(ptr) + off;
        if (s >= NPORTS)
            s = s - NPORTS;
        return c_IDW'(s);
    endfunction

    // Round-robin: first eligible port after the last granted one. Scan from
    // farthest to nearest so the nearest eligible port is the one that sticks.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int i = NPORTS; i >= 1; i--) begin
            if (w_elig[rr_idx(r_ptr, i)]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = rr_idx(r_ptr, i);
            end
        end
    end

    // Pointer remembers the last granted port; reset value makes port 0 first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= c_IDW'(NPORTS - 1);
        else if (w_gnt_valid)
            r_ptr <= w_gnt_idx;
    end
`endif

    // Route the granted port's command to the single memory port.
    assign w_sel_we    = bus.we[w_gnt_idx];
    assign w_sel_addr  = bus.addr[int'(w_gnt_idx) * AW +: AW];
    assign w_sel_wdata = bus.wdata[int'(w_gnt_idx) * DW +: DW];
    assign w_in_range  = (w_sel_addr >> DEPTH_LOG2) == '0;
    assign w_mem_idx   = w_sel_addr[DEPTH_LOG2-1:0];
    // Reset is asserted asynchronously, so keep it from letting a write
    // slip in on an edge that occurs while it is held.
    assign w_wr_en     = w_gnt_valid & w_sel_we & w_in_range & ~reset;

    // Ack, read data and grant probe; all hold when nobody is eligible
    // except rdy, which is a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy    <= '0;
            r_rdata  <= '0;
            r_gnt_id <= '0;
        end else if (w_gnt_valid) begin
            r_rdy    <= NPORTS'(1) << w_gnt_idx;
            r_gnt_id <= w_gnt_idx;
            if (!w_sel_we)
                r_rdata <= w_in_range ? r_mem[w_mem_idx] : MISS_DATA;
        end else begin
            r_rdy    <= '0;
        end
    end

    // Memory array is deliberately not reset; reads above see the value
    // before this edge's write.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_mem_idx] <= w_sel_wdata;
    end

    assign bus.rdy    = r_rdy;
    assign bus.rdata  = r_rdata;
    assign bus.gnt_id = r_gnt_id;

endmodule
`default_nettype wire
